dff_response_monitor: RTL and testbench
=======================================

Name: dff_response_monitor

Overview:
- Self-checking observer on the output side of an edge-triggered D flip-flop under test (ports Q, Qbar, D, CLK, RESET).
- Holds a golden DFF model driven from the same D and compares the DUT outputs every clock.
- Counts mismatches, tracks the length of consecutive mismatch runs, captures the cycle of the first failure, and latches a sticky fault.
- Catches overrides such as a forced Q that disagrees with the model.

Parameters:
- CNT_W, 16, width of the error and cycle counters.
- SETTLE_CYC, 2, cycles after RESET deasserts before checking starts (1..15).
- RUN_LIMIT, 4, consecutive mismatches that raise the sticky fault (1..2^CNT_W-1).

Ports:
- CLK  input  1  sampling clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- D  input  1  data driven into the DUT, tapped at the DUT input.
- Q  input  1  DUT true output.
- Qbar  input  1  DUT complement output.
- enable  input  1  comparisons count only while high.
- clr_err  input  1  synchronous clear of counters and fault; RESET takes priority.
- mismatch  output  1  registered 1-cycle pulse per detected mismatch.
- err_count  output  CNT_W  total mismatches, saturating.
- run_len  output  CNT_W  current consecutive-mismatch run, saturating.
- fault  output  1  sticky; set when run_len reaches RUN_LIMIT.
- first_fail  output  CNT_W  cycle_count value at the first mismatch since reset or clear.
- first_valid  output  1  first_fail holds a captured value.
- checking  output  1  high in state CHECK or FAULT.

Behaviour:
- Reset (RESET=1 at posedge): all outputs 0, q_ref=0, cycle_count=0, state=SETTLE, settle counter=0.
- Model:
  - q_ref <= D on every posedge while RESET=0.
  - Expected Q at posedge n is q_ref, which holds D from edge n-1.
- cycle_count increments every non-reset cycle and wraps at 2^CNT_W.
- States:
  - SETTLE: settle counter increments each cycle. After SETTLE_CYC cycles go to CHECK. No compares.
  - CHECK:
    - A compare happens at a posedge when enable=1 and Q != q_ref.
    - On a compare: mismatch=1 next cycle, err_count+1, run_len+1, and first_fail/first_valid captured if first_valid=0.
    - A matching compare sets run_len=0.
    - enable=0: no compare, run_len holds.
    - When run_len+1 reaches RUN_LIMIT: fault=1, go to FAULT.
  - FAULT: counting continues as in CHECK, and fault stays 1. clr_err returns to CHECK.
- clr_err (RESET=0):
  - Clears err_count, run_len, fault, first_valid, first_fail and mismatch.
  - Does not clear q_ref or cycle_count.
  - A compare in the same cycle is discarded.
- Saturation: err_count and run_len stick at 2^CNT_W-1.
- RESET asserted mid-run: everything above returns to reset values at that edge, and SETTLE restarts.
- Latency: the mismatch pulse appears one cycle after the offending sample edge. err_count updates on the same edge as the pulse.

Optional Feature:
- Macro: DFFMON_COMPL_CHECK_EN.
- Defined:
  - Adds output compl_err (1 bit, reset 0).
  - compl_err is a registered pulse whenever Q == Qbar during CHECK/FAULT with enable=1.
  - A complement error also counts as a mismatch: increments err_count and run_len, and can raise fault.
  - If Q != q_ref and Q == Qbar in the same cycle, counters increment by 1 only.
- Undefined: port absent; Qbar is ignored.

Test Plan:
1. Reset plus settle: RESET=1 for 3 cycles, then release with SETTLE_CYC=2, D toggling and DUT correct → checking=1 at the 3rd cycle after release; err_count=0; mismatch never pulses.
2. Forced output: D=0 and Q forced to 1 for 5 cycles starting at cycle 10 after reset, RUN_LIMIT=4 → 5 mismatch pulses; err_count=5; first_fail=10; fault=1 after the 4th pulse; run_len=0 after release.
3. Enable gating: enable=0 during 3 mismatching cycles, then enable=1 for 2 more mismatching cycles → err_count=2, run_len=2, fault=0.
4. Saturation and clear: CNT_W=4 with 20 mismatches → err_count=15. Then clr_err=1 together with a mismatch → err_count=0, fault=0, first_valid=0, no pulse.
5. Mid-run reset: RESET asserted while run_len=3 → all outputs 0 next cycle; state SETTLE; the following correct traffic gives err_count=0.
6. With DFFMON_COMPL_CHECK_EN defined: Q=Qbar=1 while q_ref=1 for 1 cycle → compl_err pulse; err_count+1; mismatch pulse.

Source files
------------

// File: rtl/dff_response_monitor.sv
// Golden-model observer for a D flip-flop under test: counts output mismatches and raises a sticky fault.
// Optional macro DFFMON_COMPL_CHECK_EN adds the Q/Qbar complement check and the compl_err output.
module dff_response_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned RUN_LIMIT  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             D,
  input  logic             Q,
  input  logic             Qbar,
  input  logic             enable,
  input  logic             clr_err,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] run_len,
  output logic             fault,
  output logic [CNT_W-1:0] first_fail,
  output logic             first_valid,
  output logic             checking
`ifdef DFFMON_COMPL_CHECK_EN
  ,
  output logic             compl_err
`endif
);

  localparam int unsigned SET_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               q_ref;
  logic [CNT_W-1:0]   cycle_count;
  logic               cmp_en;
  logic               q_bad;
  logic               compl_bad;
  logic               any_bad;
  logic               hit;
  logic               limit_hit;
  logic [CNT_W-1:0]   err_inc;
  logic [CNT_W-1:0]   run_inc;

  // Compare qualification; a clear in the same cycle discards the compare
  assign cmp_en    = (state_q != ST_SETTLE) && enable;
  assign q_bad     = (Q != q_ref);
`ifdef DFFMON_COMPL_CHECK_EN
  assign compl_bad = (Q == Qbar);
`else
  logic unused_qbar;
  assign unused_qbar = Qbar;
  assign compl_bad   = 1'b0;
`endif
  assign any_bad   = q_bad || compl_bad;
  assign hit       = cmp_en && any_bad && !clr_err;
  assign err_inc   = (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);
  assign run_inc   = (run_len == CNT_MAX) ? run_len : run_len + CNT_W'(1);
  assign limit_hit = hit && (run_inc >= CNT_W'(RUN_LIMIT));

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC)) state_d = ST_CHECK;
        else                                settle_d = settle_q + SET_W'(1);
      end
      ST_CHECK: begin
        if (limit_hit) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (clr_err) state_d = ST_CHECK;
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // Golden model, counters and registered status outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_ref       <= 1'b0;
      cycle_count <= '0;
      mismatch    <= 1'b0;
      err_count   <= '0;
      run_len     <= '0;
      fault       <= 1'b0;
      first_fail  <= '0;
      first_valid <= 1'b0;
      checking    <= 1'b0;
`ifdef DFFMON_COMPL_CHECK_EN
      compl_err   <= 1'b0;
`endif
    end else begin
      q_ref       <= D;
      cycle_count <= cycle_count + CNT_W'(1);
      checking    <= (state_d != ST_SETTLE);
      if (clr_err) begin
        mismatch    <= 1'b0;
        err_count   <= '0;
        run_len     <= '0;
        fault       <= 1'b0;
        first_fail  <= '0;
        first_valid <= 1'b0;
`ifdef DFFMON_COMPL_CHECK_EN
        compl_err   <= 1'b0;
`endif
      end else begin
        mismatch <= hit;
`ifdef DFFMON_COMPL_CHECK_EN
        compl_err <= cmp_en && compl_bad;
`endif
        if (hit) begin
          err_count <= err_inc;
          run_len   <= run_inc;
          if (!first_valid) begin
            first_valid <= 1'b1;
            first_fail  <= cycle_count;
          end
          if (limit_hit) fault <= 1'b1;
        end else if (cmp_en) begin
          run_len <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dff_response_monitor.sv
// Randomized self-checking bench for dff_response_monitor against an arithmetic reference model.
module tb_dff_response_monitor;

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned RUN_LIMIT  = 4;
  localparam int          MAXV       = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             D = 1'b0;
  logic             Q = 1'b0;
  logic             Qbar = 1'b1;
  logic             enable = 1'b1;
  logic             clr_err = 1'b0;
  logic             mismatch;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] run_len;
  logic             fault;
  logic [CNT_W-1:0] first_fail;
  logic             first_valid;
  logic             checking;
`ifdef DFFMON_COMPL_CHECK_EN
  logic             compl_err;
`endif

  dff_response_monitor #(
    .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .RUN_LIMIT(RUN_LIMIT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .D(D), .Q(Q), .Qbar(Qbar),
    .enable(enable), .clr_err(clr_err),
    .mismatch(mismatch), .err_count(err_count), .run_len(run_len),
    .fault(fault), .first_fail(first_fail), .first_valid(first_valid),
    .checking(checking)
`ifdef DFFMON_COMPL_CHECK_EN
    , .compl_err(compl_err)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state: cycles since reset release, plain integer counters
  bit m_ref;
  int m_cyc, m_since, m_err, m_run, m_ff;
  bit m_fault, m_fv, m_mism, m_chk, m_compl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit active, wrong, qb_eq;
    if (RESET) begin
      m_ref = 0; m_cyc = 0; m_since = 0; m_err = 0; m_run = 0; m_ff = 0;
      m_fault = 0; m_fv = 0; m_mism = 0; m_chk = 0; m_compl = 0;
      return;
    end
    active = m_chk && enable;
    qb_eq  = (Q == Qbar);
`ifdef DFFMON_COMPL_CHECK_EN
    wrong = (Q != m_ref) || qb_eq;
`else
    wrong = (Q != m_ref);
`endif
    if (clr_err) begin
      m_err = 0; m_run = 0; m_fault = 0; m_fv = 0; m_ff = 0; m_mism = 0; m_compl = 0;
    end else begin
      m_mism  = active && wrong;
      m_compl = active && qb_eq;
      if (active && wrong) begin
        m_err = (m_err + 1 > MAXV) ? MAXV : m_err + 1;
        m_run = (m_run + 1 > MAXV) ? MAXV : m_run + 1;
        if (!m_fv) begin m_fv = 1; m_ff = m_cyc; end
        if (m_run >= RUN_LIMIT) m_fault = 1;
      end else if (active) begin
        m_run = 0;
      end
    end
    if (m_since < 1000) m_since++;
    m_chk = (m_since >= SETTLE_CYC + 1);
    m_ref = D;
    m_cyc = (m_cyc + 1) % (MAXV + 1);
  endtask

  task automatic compare_all();
    check("mismatch", 32'(mismatch), 32'(m_mism));
    check("err_count", 32'(err_count), 32'(m_err));
    check("run_len", 32'(run_len), 32'(m_run));
    check("fault", 32'(fault), 32'(m_fault));
    check("first_fail", 32'(first_fail), 32'(m_ff));
    check("first_valid", 32'(first_valid), 32'(m_fv));
    check("checking", 32'(checking), 32'(m_chk));
`ifdef DFFMON_COMPL_CHECK_EN
    check("compl_err", 32'(compl_err), 32'(m_compl));
`endif
  endtask

  // One clock: drive away from the edge, update model at the edge, sample 1 ns later
  task automatic step(input bit rst, input bit d, input bit en, input bit clr,
                      input bit qbad, input bit qbeq);
    @(negedge CLK);
    RESET   = rst;
    D       = d;
    enable  = en;
    clr_err = clr;
    Q       = qbad ? ~m_ref : m_ref;
    Qbar    = qbeq ? Q : ~Q;
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    // Reset and settle with correct, toggling traffic
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_checking", 32'(checking), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 1'(i), 1, 0, 0, 0);
    check("settle_checking", 32'(checking), 32'd1);
    check("settle_err", 32'(err_count), 32'd0);

    // Forced output for 5 cycles with D held low
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1, 0);
    check("force_err", 32'(err_count), 32'd5);
    check("force_fault", 32'(fault), 32'd1);
    for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, 0);
    check("force_run_release", 32'(run_len), 32'd0);

    // Enable gating
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 1, 0);
    check("gate_err", 32'(err_count), 32'd2);
    check("gate_run", 32'(run_len), 32'd2);
    check("gate_fault", 32'(fault), 32'd0);

    // Saturation then clear concurrent with a mismatch
    for (int i = 0; i < 20; i++) step(0, 1'($urandom), 1, 0, 1, 0);
    check("sat_err", 32'(err_count), 32'(MAXV));
    check("sat_run", 32'(run_len), 32'(MAXV));
    step(0, 0, 1, 1, 1, 0);
    check("clr_err_cnt", 32'(err_count), 32'd0);
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_first_valid", 32'(first_valid), 32'd0);
    check("clr_pulse", 32'(mismatch), 32'd0);

    // Mid-run reset
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0);
    check("pre_rst_run", 32'(run_len), 32'd3);
    step(1, 0, 1, 0, 0, 0);
    check("midrst_run", 32'(run_len), 32'd0);
    check("midrst_err", 32'(err_count), 32'd0);
    check("midrst_checking", 32'(checking), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 1'($urandom), 1, 0, 0, 0);
    check("post_rst_err", 32'(err_count), 32'd0);

`ifdef DFFMON_COMPL_CHECK_EN
    // Complement error with Q matching the model
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    check("compl_pulse", 32'(compl_err), 32'd1);
    check("compl_mismatch", 32'(mismatch), 32'd1);
    check("compl_err_cnt", 32'(err_count), 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), 1'($urandom),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
